// File: rtl/braille_rand_sched_if.sv
// rtl/braille_rand_sched_if.sv - requester and LFSR signal bundle for braille_rand_sched
// Purpose: groups the request/acknowledge handshake and the LFSR hookup so the
// scheduler (slave) and the requester/LFSR side (master) share one port.
// Signals (direction as seen by the slave):
//   req         in   2      level request per requester, held until its ack
//   lfsr_q      in   16     LFSR state word
//   lfsr_start  out  1      LFSR run enable
//   ack         out  2      one-cycle grant/data-valid pulse per requester
//   rand_val    out  SYM_W  symbol index, valid while any ack bit is high
//   busy        out  1      warmup or draw in progress
interface braille_rand_sched_if #(
  parameter int SYM_W = 5
);
  logic [1:0]       req;
  logic [15:0]      lfsr_q;
  logic             lfsr_start;
  logic [1:0]       ack;
  logic [SYM_W-1:0] rand_val;
  logic             busy;

  modport master (
    output req,
    output lfsr_q,
    input  lfsr_start,
    input  ack,
    input  rand_val,
    input  busy
  );

  modport slave (
    input  req,
    input  lfsr_q,
    output lfsr_start,
    output ack,
    output rand_val,
    output busy
  );
endinterface

// File: rtl/braille_rand_sched.sv
// rtl/braille_rand_sched.sv - shares one 16-bit LFSR between two requesters, returns uniform symbol indices
// Purpose: owns the LFSR start enable, warms the sequence up on first use,
// arbitrates round-robin between the prompt generator (0) and dot shuffler (1)
// and reduces the LFSR word to [0, NUM_SYMBOLS-1] by rejection sampling.
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  asynchronous active-low reset
//   bus   braille_rand_sched_if.slave (req, lfsr_q in; lfsr_start, ack, rand_val, busy out)
// Optional feature macro: BRAILLE_RAND_NOREPEAT_EN - rejects a sample equal to the
// value last delivered to the same requester.
module braille_rand_sched #(
  parameter int NUM_SYMBOLS = 26,
  parameter int SYM_W       = 5,
  parameter int WARMUP_CYC  = 16,
  parameter int MAX_TRY     = 8
) (
  input  logic                clk,
  input  logic                rst,
  braille_rand_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WARMUP, READY, DRAW} state_t;

  localparam logic [SYM_W:0] NUM_SYM   = (SYM_W+1)'(NUM_SYMBOLS);
  localparam logic [SYM_W:0] ONE_SYM   = (SYM_W+1)'(1);
  localparam logic [7:0]     WARM_LAST = 8'(WARMUP_CYC - 1);
  localparam logic [3:0]     TRY_LAST  = 4'(MAX_TRY - 1);

  state_t           state_q, state_d;
  logic [7:0]       warm_cnt_q, warm_cnt_d;
  logic [3:0]       tries_q, tries_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic [1:0]       ack_q, ack_d;
  logic [SYM_W-1:0] rand_val_q, rand_val_d;

  // One extra bit so NUM_SYMBOLS == 2^SYM_W and the history "no match" value fit.
  logic [SYM_W:0]   samp;
  logic [SYM_W:0]   fold_val;
  logic [SYM_W:0]   pick;
  logic             in_range;
  logic             accept_ok;
  logic [1:0]       req_m;

`ifdef BRAILLE_RAND_NOREPEAT_EN
  logic [1:0][SYM_W:0] hist_q, hist_d;
`endif

  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    tries_d    = tries_q;
    owner_d    = owner_q;
    last_d     = last_q;
    start_d    = start_q;
    rand_val_d = rand_val_q;
    ack_d      = 2'b00;

    // A requester being acked this cycle may still be lowering req.
    req_m    = bus.req & ~ack_q;
    samp     = {1'b0, bus.lfsr_q[SYM_W-1:0]};
    in_range = samp < NUM_SYM;
    fold_val = in_range ? samp : samp - NUM_SYM;

`ifdef BRAILLE_RAND_NOREPEAT_EN
    hist_d    = hist_q;
    accept_ok = in_range && (samp != hist_q[owner_q]);
    if (fold_val == hist_q[owner_q]) begin
      fold_val = (fold_val == NUM_SYM - ONE_SYM) ? '0 : fold_val + ONE_SYM;
    end
`else
    accept_ok = in_range;
`endif

    pick = accept_ok ? samp : fold_val;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d    = WARMUP;
          warm_cnt_d = '0;
          start_d    = 1'b1;
        end
      end
      WARMUP: begin
        if (warm_cnt_q == WARM_LAST) begin
          state_d = READY;
        end else begin
          warm_cnt_d = warm_cnt_q + 8'd1;
        end
      end
      READY: begin
        if (|req_m) begin
          owner_d = (req_m == 2'b11) ? ~last_q : req_m[1];
          tries_d = '0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (accept_ok || (tries_q >= TRY_LAST)) begin
          rand_val_d     = pick[SYM_W-1:0];
          ack_d[owner_q] = 1'b1;
          last_d         = owner_q;
          state_d        = READY;
`ifdef BRAILLE_RAND_NOREPEAT_EN
          hist_d[owner_q] = pick;
`endif
        end else begin
          tries_d = tries_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == WARMUP) || (state_d == DRAW);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      warm_cnt_q <= '0;
      tries_q    <= '0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 2'b00;
      rand_val_q <= '0;
`ifdef BRAILLE_RAND_NOREPEAT_EN
      hist_q     <= {2{NUM_SYM}};
`endif
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      tries_q    <= tries_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      rand_val_q <= rand_val_d;
`ifdef BRAILLE_RAND_NOREPEAT_EN
      hist_q     <= hist_d;
`endif
    end
  end

  assign bus.lfsr_start = start_q;
  assign bus.busy       = busy_q;
  assign bus.ack        = ack_q;
  assign bus.rand_val   = rand_val_q;

  logic unused_bits;
  assign unused_bits = ^{bus.lfsr_q[15:SYM_W], pick[SYM_W]};

endmodule

// File: tb/tb_braille_rand_sched.sv
// tb/tb_braille_rand_sched.sv - directed self-checking bench for braille_rand_sched
module tb_braille_rand_sched;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  braille_rand_sched_if #(.SYM_W(5)) bus ();

  braille_rand_sched #(
    .NUM_SYMBOLS(26),
    .SYM_W(5),
    .WARMUP_CYC(16),
    .MAX_TRY(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [1:0]  arb_ack [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
  logic [15:0] arb_lfsr[6] = '{16'h0004, 16'h0009, 16'h0011, 16'h0001, 16'h0016, 16'h0018};
  logic [4:0]  arb_val [6] = '{5'd4, 5'd9, 5'd17, 5'd1, 5'd22, 5'd24};

  task automatic test_reset();
    rst = 1'b0;
    bus.req = 2'b00;
    bus.lfsr_q = 16'h0000;
    repeat (2) @(negedge clk);
    total++; if (bus.lfsr_start !== 1'b0) begin bad++; $display("FAIL reset_lfsr_start got=%b exp=0", bus.lfsr_start); end
    total++; if (bus.ack !== 2'b00) begin bad++; $display("FAIL reset_ack got=%b exp=00", bus.ack); end
    total++; if (bus.rand_val !== 5'd0) begin bad++; $display("FAIL reset_rand_val got=%0d exp=0", bus.rand_val); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.lfsr_start !== 1'b0) begin bad++; $display("FAIL idle_no_req_start got=%b exp=0", bus.lfsr_start); end
  endtask

  task automatic test_cold_start();
    int n;
    bus.lfsr_q = 16'h0007;
    bus.req = 2'b01;
    @(negedge clk);
    total++; if (bus.lfsr_start !== 1'b1) begin bad++; $display("FAIL cold_lfsr_start got=%b exp=1", bus.lfsr_start); end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy !== 1'b1) break;
      n++;
      @(negedge clk);
    end
    total++; if (n != 16) begin bad++; $display("FAIL cold_warmup_len got=%0d exp=16", n); end
    total++; if (bus.ack !== 2'b00) begin bad++; $display("FAIL cold_ready_ack got=%b exp=00", bus.ack); end
    @(negedge clk);
    total++; if (bus.busy !== 1'b1 || bus.ack !== 2'b00) begin bad++; $display("FAIL cold_draw busy=%b ack=%b exp busy=1 ack=00", bus.busy, bus.ack); end
    @(negedge clk);
    total++; if (bus.ack !== 2'b01) begin bad++; $display("FAIL cold_ack got=%b exp=01", bus.ack); end
    total++; if (bus.rand_val !== 5'd7) begin bad++; $display("FAIL cold_rand_val got=%0d exp=7", bus.rand_val); end
    bus.req = 2'b00;
    @(negedge clk);
    total++; if (bus.ack !== 2'b00) begin bad++; $display("FAIL cold_ack_pulse got=%b exp=00", bus.ack); end
    total++; if (bus.rand_val !== 5'd7) begin bad++; $display("FAIL cold_rand_hold got=%0d exp=7", bus.rand_val); end
    total++; if (bus.lfsr_start !== 1'b1) begin bad++; $display("FAIL cold_start_stays got=%b exp=1", bus.lfsr_start); end
  endtask

  task automatic test_rejection();
    bus.lfsr_q = 16'h001E;
    bus.req = 2'b01;
    @(negedge clk);
    total++; if (bus.busy !== 1'b1 || bus.ack !== 2'b00) begin bad++; $display("FAIL rej_enter busy=%b ack=%b exp busy=1 ack=00", bus.busy, bus.ack); end
    @(negedge clk);
    total++; if (bus.ack !== 2'b00) begin bad++; $display("FAIL rej_30 got=%b exp=00", bus.ack); end
    bus.lfsr_q = 16'hA51B;
    @(negedge clk);
    total++; if (bus.ack !== 2'b00) begin bad++; $display("FAIL rej_27 got=%b exp=00", bus.ack); end
    bus.lfsr_q = 16'hFFE3;
    @(negedge clk);
    total++; if (bus.ack !== 2'b01) begin bad++; $display("FAIL rej_ack got=%b exp=01", bus.ack); end
    total++; if (bus.rand_val !== 5'd3) begin bad++; $display("FAIL rej_rand_val got=%0d exp=3", bus.rand_val); end
    bus.req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_fold();
    int n;
    bus.lfsr_q = 16'h001F;
    bus.req = 2'b10;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (bus.ack !== 2'b00) break;
    end
    total++; if (n != 9) begin bad++; $display("FAIL fold_latency got=%0d exp=9", n); end
    total++; if (bus.ack !== 2'b10) begin bad++; $display("FAIL fold_ack got=%b exp=10", bus.ack); end
    total++; if (bus.rand_val !== 5'd5) begin bad++; $display("FAIL fold_rand_val got=%0d exp=5", bus.rand_val); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL fold_busy got=%b exp=0", bus.busy); end
    bus.req = 2'b00;
    @(negedge clk);
    total++; if (bus.ack !== 2'b00) begin bad++; $display("FAIL fold_ack_pulse got=%b exp=00", bus.ack); end
  endtask

  task automatic test_arbitration();
    int n;
    bus.lfsr_q = arb_lfsr[0];
    bus.req = 2'b11;
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (bus.ack !== 2'b00) break;
      end
      total++; if (bus.ack !== arb_ack[k]) begin bad++; $display("FAIL arb_ack_%0d got=%b exp=%b", k, bus.ack, arb_ack[k]); end
      total++; if (bus.rand_val !== arb_val[k]) begin bad++; $display("FAIL arb_val_%0d got=%0d exp=%0d", k, bus.rand_val, arb_val[k]); end
      if (k < 5) bus.lfsr_q = arb_lfsr[k+1];
      if (k == 4) bus.req = 2'b10;
      if (k == 5) bus.req = 2'b00;
    end
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.ack !== 2'b00) n++;
    end
    total++; if (n != 0) begin bad++; $display("FAIL arb_no_reserve got=%0d exp=0", n); end
  endtask

  task automatic test_async_reset();
    int n;
    bus.lfsr_q = 16'h001F;
    bus.req = 2'b01;
    repeat (3) @(negedge clk);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ar_mid_draw_busy got=%b exp=1", bus.busy); end
    #2 rst = 1'b0;
    #1;
    total++; if (bus.ack !== 2'b00) begin bad++; $display("FAIL ar_ack got=%b exp=00", bus.ack); end
    total++; if (bus.lfsr_start !== 1'b0) begin bad++; $display("FAIL ar_lfsr_start got=%b exp=0", bus.lfsr_start); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ar_busy got=%b exp=0", bus.busy); end
    total++; if (bus.rand_val !== 5'd0) begin bad++; $display("FAIL ar_rand_val got=%0d exp=0", bus.rand_val); end
    bus.lfsr_q = 16'h0002;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.lfsr_start !== 1'b1) begin bad++; $display("FAIL ar_restart got=%b exp=1", bus.lfsr_start); end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy !== 1'b1) break;
      n++;
      @(negedge clk);
    end
    total++; if (n != 16) begin bad++; $display("FAIL ar_warmup_len got=%0d exp=16", n); end
    repeat (2) @(negedge clk);
    total++; if (bus.ack !== 2'b01 || bus.rand_val !== 5'd2) begin bad++; $display("FAIL ar_first_draw ack=%b val=%0d exp ack=01 val=2", bus.ack, bus.rand_val); end
    bus.req = 2'b00;
    @(negedge clk);
  endtask

`ifdef BRAILLE_RAND_NOREPEAT_EN
  task automatic test_norepeat();
    bus.lfsr_q = 16'h000C;
    bus.req = 2'b01;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.ack !== 2'b00) break;
    end
    total++; if (bus.ack !== 2'b01 || bus.rand_val !== 5'd12) begin bad++; $display("FAIL nr_first ack=%b val=%0d exp ack=01 val=12", bus.ack, bus.rand_val); end
    bus.req = 2'b00;
    @(negedge clk);
    bus.req = 2'b01;
    repeat (2) @(negedge clk);
    total++; if (bus.ack !== 2'b00) begin bad++; $display("FAIL nr_repeat_rejected got=%b exp=00", bus.ack); end
    bus.lfsr_q = 16'h0009;
    @(negedge clk);
    total++; if (bus.ack !== 2'b01 || bus.rand_val !== 5'd9) begin bad++; $display("FAIL nr_second ack=%b val=%0d exp ack=01 val=9", bus.ack, bus.rand_val); end
    bus.req = 2'b00;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_cold_start();
    test_rejection();
    test_fold();
    test_arbitration();
    test_async_reset();
`ifdef BRAILLE_RAND_NOREPEAT_EN
    test_norepeat();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
